// File: rtl/sdfm_dfilt_if.sv
// Channel-side bundle for one SDFM data filter: modulator bit stream in, result FIFO read port out.
interface sdfm_dfilt_if #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 3
);
  logic             bit_valid;
  logic             bit_in;
  logic             rd_en;
  logic [ACC_W-1:0] rd_data;
  logic             empty;
  logic [CNT_W-1:0] level;

  modport master (
    output bit_valid, bit_in, rd_en,
    input  rd_data, empty, level
  );

  modport slave (
    input  bit_valid, bit_in, rd_en,
    output rd_data, empty, level
  );
endinterface

// File: rtl/sdfm_dfilt.sv
// Sigma-delta data filter: runtime Sinc1/2/3 CIC decimator with programmable ratio,
// three-stage pipeline (integrate, comb, push) feeding a show-ahead result FIFO.
module sdfm_dfilt #(
  parameter int DEC_W      = 16,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             SYSCLK,
  input  logic             SYSRSTn,
  sdfm_dfilt_if.slave      bus,
  input  logic             reg_filten,
  input  logic [1:0]       reg_filtst,
  input  logic [DEC_W-1:0] reg_filtdec,
  input  logic             reg_filtask,
  input  logic             ovf_clr,
  output logic             ovf,
  output logic             irq
);
  localparam int PTR_W = CNT_W - 1;

  // shadow configuration
  logic             filten_q;
  logic [1:0]       shd_st;
  logic [DEC_W-1:0] shd_dec;
  logic             en_rise;
  logic [1:0]       cur_st;
  logic [DEC_W-1:0] cur_dec;
  logic [1:0]       ord_m1;

  // the enabling cycle already runs with the incoming configuration
  always_comb begin
    en_rise = reg_filten & ~filten_q;
    cur_st  = en_rise ? reg_filtst  : shd_st;
    cur_dec = en_rise ? reg_filtdec : shd_dec;
    case (cur_st)
      2'b00:   ord_m1 = 2'd0;
      2'b01:   ord_m1 = 2'd1;
      default: ord_m1 = 2'd2;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      filten_q <= 1'b0;
      shd_st   <= 2'b00;
      shd_dec  <= '0;
    end else begin
      filten_q <= reg_filten;
      if (en_rise) begin
        shd_st  <= reg_filtst;
        shd_dec <= reg_filtdec;
      end
    end
  end

  // integrate stage
  logic [ACC_W-1:0] x_map;
  logic [ACC_W-1:0] int1, int2, int3;
  logic [ACC_W-1:0] int1_n, int2_n, int3_n;
  logic [DEC_W-1:0] dec_cnt;
  logic [1:0]       settle_cnt;
  logic             dec_evt;
  logic             ev1;
  logic             ev1_push;

  always_comb begin
    x_map   = {{(ACC_W-1){~bus.bit_in}}, 1'b1};
    int1_n  = int1 + x_map;
    int2_n  = int2 + int1_n;
    int3_n  = int3 + int2_n;
    dec_evt = bus.bit_valid & (dec_cnt == cur_dec);
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      int1       <= '0;
      int2       <= '0;
      int3       <= '0;
      dec_cnt    <= '0;
      settle_cnt <= 2'd0;
      ev1        <= 1'b0;
      ev1_push   <= 1'b0;
    end else if (!reg_filten) begin
      int1       <= '0;
      int2       <= '0;
      int3       <= '0;
      dec_cnt    <= '0;
      settle_cnt <= 2'd0;
      ev1        <= 1'b0;
      ev1_push   <= 1'b0;
    end else begin
      ev1      <= dec_evt;
      ev1_push <= dec_evt & (settle_cnt >= ord_m1);
      if (bus.bit_valid) begin
        int1 <= int1_n;
        int2 <= int2_n;
        int3 <= int3_n;
        if (dec_evt) begin
          dec_cnt <= '0;
          if (settle_cnt < ord_m1) settle_cnt <= settle_cnt + 2'd1;
        end else begin
          dec_cnt <= dec_cnt + DEC_W'(1);
        end
      end
    end
  end

  // comb stage: suppressed events still advance the comb history
  logic [ACC_W-1:0] int_sel, c1, c2, c3, y;
  logic [ACC_W-1:0] cp1, cp2, cp3, res;
  logic             ev2;

  always_comb begin
    case (ord_m1)
      2'd0:    int_sel = int1;
      2'd1:    int_sel = int2;
      default: int_sel = int3;
    endcase
    c1 = int_sel - cp1;
    c2 = c1 - cp2;
    c3 = c2 - cp3;
    case (ord_m1)
      2'd0:    y = c1;
      2'd1:    y = c2;
      default: y = c3;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      cp1 <= '0;
      cp2 <= '0;
      cp3 <= '0;
      res <= '0;
      ev2 <= 1'b0;
    end else if (!reg_filten) begin
      cp1 <= '0;
      cp2 <= '0;
      cp3 <= '0;
      res <= '0;
      ev2 <= 1'b0;
    end else begin
      ev2 <= ev1 & ev1_push;
      if (ev1) begin
        cp1 <= int_sel;
        cp2 <= c1;
        cp3 <= c2;
        res <= y;
      end
    end
  end

  // push stage and result FIFO
  logic [ACC_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] level_q;
  logic             push, pop, wr, drop, full, empty_w;

  always_comb begin
    empty_w = (level_q == '0);
    full    = (level_q == CNT_W'(FIFO_DEPTH));
    push    = ev2 & reg_filten;
    pop     = bus.rd_en & ~empty_w;
    wr      = push & (~full | pop);
    drop    = push & full & ~pop;
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= res;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr, pop})
        2'b10:   level_q <= level_q + CNT_W'(1);
        2'b01:   level_q <= level_q - CNT_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // a new overflow beats a coincident clear
  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      ovf <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      irq <= reg_filtask & (~empty_w | ovf);
    end
  end

  assign bus.rd_data = mem[rd_ptr];
  assign bus.empty   = empty_w;
  assign bus.level   = level_q;

endmodule
